// File: rtl/mem_port_arb_if.sv
// Bus bundle between the fetch/load-store requesters, the memory array and mem_port_arb.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_port_arb_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_W     = 10
);
  logic                  i_if_req;
  logic [ADDR_W-1:0]     i_if_addr;
  logic                  i_if_flush;
  logic                  o_if_gnt;
  logic                  o_if_vld;
  logic [DATA_WIDTH-1:0] o_if_rdata;

  logic                  i_ls_req;
  logic                  i_ls_we;
  logic [ADDR_W-1:0]     i_ls_addr;
  logic [DATA_WIDTH-1:0] i_ls_wdata;
  logic                  o_ls_gnt;
  logic                  o_ls_vld;
  logic [DATA_WIDTH-1:0] o_ls_rdata;

  logic                  o_mem_en;
  logic                  o_mem_we;
  logic [ADDR_W-1:0]     o_mem_addr;
  logic [DATA_WIDTH-1:0] o_mem_wdata;
  logic [DATA_WIDTH-1:0] i_mem_rdata;

  modport slave (
    input  i_if_req, i_if_addr, i_if_flush,
    output o_if_gnt, o_if_vld, o_if_rdata,
    input  i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata,
    output o_ls_gnt, o_ls_vld, o_ls_rdata,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    input  i_mem_rdata
  );

  modport master (
    output i_if_req, i_if_addr, i_if_flush,
    input  o_if_gnt, o_if_vld, o_if_rdata,
    output i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata,
    input  o_ls_gnt, o_ls_vld, o_ls_rdata,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    output i_mem_rdata
  );
endinterface

// File: rtl/mem_port_arb.sv
// Single-cycle arbiter sharing one single-port memory between instruction fetch and
// load/store. Load/store wins by default; a saturating wait counter bounds fetch starvation.
module mem_port_arb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 1024,
  parameter int unsigned MAX_WAIT   = 4
) (
  input logic           clk,
  input logic           rst,
  mem_port_arb_if.slave arb_io
);
  localparam int unsigned ADDR_W = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {OwnNone, OwnIf, OwnLsRd, OwnLsWr} owner_e;

  owner_e                owner_q, owner_d;
  logic [3:0]            wait_q, wait_d;
  logic                  if_ok, ls_ok, if_gnt, ls_gnt;
  logic                  if_vld, ls_vld;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  always_comb begin
    if_ok  = arb_io.i_if_req & ~arb_io.i_if_flush;
    ls_ok  = arb_io.i_ls_req;
    // Grants are gated by rst so nothing reaches the memory while reset is asserted.
    if_gnt = ~rst & if_ok & (~ls_ok | (wait_q >= 4'(MAX_WAIT)));
    ls_gnt = ~rst & ls_ok & ~if_gnt;

    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    owner_d   = OwnNone;
    if (if_gnt) begin
      mem_addr = arb_io.i_if_addr;
      owner_d  = OwnIf;
    end else if (ls_gnt) begin
      mem_we    = arb_io.i_ls_we;
      mem_addr  = arb_io.i_ls_addr;
      mem_wdata = arb_io.i_ls_wdata;
      owner_d   = arb_io.i_ls_we ? OwnLsWr : OwnLsRd;
    end

    wait_d = wait_q;
    if (if_gnt | ~arb_io.i_if_req | arb_io.i_if_flush) begin
      wait_d = '0;
    end else if (if_ok && wait_q != 4'hF) begin
      wait_d = wait_q + 4'd1;
    end

    // A flush in the response cycle kills the fetch data from the previous grant.
    if_vld = ~rst & (owner_q == OwnIf) & ~arb_io.i_if_flush;
    ls_vld = ~rst & ((owner_q == OwnLsRd) | (owner_q == OwnLsWr));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OwnNone;
      wait_q  <= '0;
    end else begin
      owner_q <= owner_d;
      wait_q  <= wait_d;
    end
  end

  assign arb_io.o_if_gnt    = if_gnt;
  assign arb_io.o_ls_gnt    = ls_gnt;
  assign arb_io.o_mem_en    = if_gnt | ls_gnt;
  assign arb_io.o_mem_we    = mem_we;
  assign arb_io.o_mem_addr  = mem_addr;
  assign arb_io.o_mem_wdata = mem_wdata;
  assign arb_io.o_if_vld    = if_vld;
  assign arb_io.o_ls_vld    = ls_vld;
  assign arb_io.o_if_rdata  = if_vld ? arb_io.i_mem_rdata : '0;
  assign arb_io.o_ls_rdata  = (ls_vld && owner_q == OwnLsRd) ? arb_io.i_mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb: directed scenarios plus a randomized run against a
// behavioural model of the arbitration rules and a shadow copy of the memory contents.
module tb_mem_port_arb;
  localparam int DW   = 32;
  localparam int AW   = 10;
  localparam int MAXW = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_port_arb_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus ();

  mem_port_arb #(
    .DATA_WIDTH(DW),
    .MEM_DEPTH (1024),
    .MAX_WAIT  (MAXW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .arb_io(bus)
  );

  // Behavioural single-port memory: registered read, one cycle latency.
  logic [DW-1:0] mem     [1024];
  logic [DW-1:0] ref_mem [1024];
  logic [DW-1:0] rd_q = '0;

  always @(posedge clk) begin
    if (bus.o_mem_en) begin
      if (bus.o_mem_we) mem[bus.o_mem_addr] <= bus.o_mem_wdata;
      rd_q <= mem[bus.o_mem_addr];
    end
  end
  assign bus.i_mem_rdata = rd_q;

  function automatic logic [111:0] all_out();
    return {bus.o_if_gnt, bus.o_if_vld, bus.o_if_rdata, bus.o_ls_gnt, bus.o_ls_vld,
            bus.o_ls_rdata, bus.o_mem_en, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata};
  endfunction

  task automatic drive(input logic ifr, input logic [AW-1:0] ia, input logic fl,
                       input logic lr, input logic we, input logic [AW-1:0] la,
                       input logic [DW-1:0] wd);
    bus.i_if_req   = ifr;
    bus.i_if_addr  = ia;
    bus.i_if_flush = fl;
    bus.i_ls_req   = lr;
    bus.i_ls_we    = we;
    bus.i_ls_addr  = la;
    bus.i_ls_wdata = wd;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 10'h080, 1'b0, 1'b1, 1'b1, 10'h010, 32'hFFFF_FFFF);
    @(negedge clk);
    checks++;
    if (all_out() !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", all_out());
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_lone_fetch();
    drive(1'b1, 10'h080, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if ({bus.o_if_gnt, bus.o_ls_gnt, bus.o_mem_en, bus.o_mem_we, bus.o_mem_addr} !==
        {1'b1, 1'b0, 1'b1, 1'b0, 10'h080}) begin
      failures++;
      $display("FAIL fetch_cmd got gnt=%b ls=%b en=%b we=%b addr=%h want 1 0 1 0 080",
               bus.o_if_gnt, bus.o_ls_gnt, bus.o_mem_en, bus.o_mem_we, bus.o_mem_addr);
    end
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if ({bus.o_if_vld, bus.o_if_rdata, bus.o_ls_vld} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
      failures++;
      $display("FAIL fetch_resp got vld=%b data=%h lsvld=%b want 1 deadbeef 0",
               bus.o_if_vld, bus.o_if_rdata, bus.o_ls_vld);
    end
    next_cycle();
  endtask

  task automatic test_conflict();
    drive(1'b1, 10'h020, 1'b0, 1'b1, 1'b0, 10'h010, '0);
    @(negedge clk);
    checks++;
    if ({bus.o_if_gnt, bus.o_ls_gnt, bus.o_mem_addr} !== {1'b0, 1'b1, 10'h010}) begin
      failures++;
      $display("FAIL conflict_gnt got if=%b ls=%b addr=%h want 0 1 010",
               bus.o_if_gnt, bus.o_ls_gnt, bus.o_mem_addr);
    end
    next_cycle();
    drive(1'b1, 10'h020, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if ({bus.o_ls_vld, bus.o_ls_rdata, bus.o_if_vld, bus.o_if_gnt} !==
        {1'b1, 32'hA000_0010, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL conflict_resp got lsvld=%b data=%h ifvld=%b ifgnt=%b want 1 a0000010 0 1",
               bus.o_ls_vld, bus.o_ls_rdata, bus.o_if_vld, bus.o_if_gnt);
    end
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if ({bus.o_if_vld, bus.o_if_rdata} !== {1'b1, 32'hA000_0020}) begin
      failures++;
      $display("FAIL conflict_fetch got vld=%b data=%h want 1 a0000020",
               bus.o_if_vld, bus.o_if_rdata);
    end
    next_cycle();
  endtask

  task automatic test_starvation();
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 10'h100, 1'b0, 1'b1, 1'b0, 10'(c), '0);
      @(negedge clk);
      checks++;
      if ({bus.o_if_gnt, bus.o_ls_gnt} !== {(c == 4), (c != 4)}) begin
        failures++;
        $display("FAIL starve_cycle%0d got if=%b ls=%b want %b %b",
                 c, bus.o_if_gnt, bus.o_ls_gnt, (c == 4), (c != 4));
      end
      if (c == 5) begin
        checks++;
        if ({bus.o_if_vld, bus.o_if_rdata} !== {1'b1, 32'hA000_0100}) begin
          failures++;
          $display("FAIL starve_fetch_resp got vld=%b data=%h want 1 a0000100",
                   bus.o_if_vld, bus.o_if_rdata);
        end
      end
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

  task automatic test_store();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 10'h3FF, 32'h1234_5678);
    @(negedge clk);
    checks++;
    if ({bus.o_ls_gnt, bus.o_mem_en, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata} !==
        {1'b1, 1'b1, 1'b1, 10'h3FF, 32'h1234_5678}) begin
      failures++;
      $display("FAIL store_cmd got gnt=%b en=%b we=%b addr=%h wdata=%h want 1 1 1 3ff 12345678",
               bus.o_ls_gnt, bus.o_mem_en, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata);
    end
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 10'h3FF, '0);
    @(negedge clk);
    checks++;
    if ({bus.o_ls_vld, bus.o_ls_rdata, bus.o_mem_we} !== {1'b1, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL store_ack got vld=%b data=%h we=%b want 1 0 0",
               bus.o_ls_vld, bus.o_ls_rdata, bus.o_mem_we);
    end
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if ({bus.o_ls_vld, bus.o_ls_rdata} !== {1'b1, 32'h1234_5678}) begin
      failures++;
      $display("FAIL store_readback got vld=%b data=%h want 1 12345678",
               bus.o_ls_vld, bus.o_ls_rdata);
    end
    next_cycle();
  endtask

  task automatic test_flush();
    drive(1'b1, 10'h040, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if (bus.o_if_gnt !== 1'b1) begin
      failures++;
      $display("FAIL flush_first_gnt got=%b want=1", bus.o_if_gnt);
    end
    next_cycle();
    drive(1'b1, 10'h044, 1'b1, 1'b1, 1'b0, 10'h010, '0);
    @(negedge clk);
    checks++;
    if ({bus.o_if_gnt, bus.o_if_vld, bus.o_if_rdata, bus.o_ls_gnt} !==
        {1'b0, 1'b0, 32'h0, 1'b1}) begin
      failures++;
      $display("FAIL flush_cycle got ifgnt=%b ifvld=%b data=%h lsgnt=%b want 0 0 0 1",
               bus.o_if_gnt, bus.o_if_vld, bus.o_if_rdata, bus.o_ls_gnt);
    end
    next_cycle();
    drive(1'b1, 10'h044, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if ({bus.o_if_gnt, bus.o_ls_vld, bus.o_ls_rdata, bus.o_if_vld} !==
        {1'b1, 1'b1, 32'hA000_0010, 1'b0}) begin
      failures++;
      $display("FAIL flush_after got ifgnt=%b lsvld=%b data=%h ifvld=%b want 1 1 a0000010 0",
               bus.o_if_gnt, bus.o_ls_vld, bus.o_ls_rdata, bus.o_if_vld);
    end
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if ({bus.o_if_vld, bus.o_if_rdata} !== {1'b1, 32'hA000_0044}) begin
      failures++;
      $display("FAIL flush_refetch got vld=%b data=%h want 1 a0000044",
               bus.o_if_vld, bus.o_if_rdata);
    end
    next_cycle();
  endtask

  task automatic test_reset_midop();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 10'h010, '0);
    @(negedge clk);
    checks++;
    if (bus.o_ls_gnt !== 1'b1) begin
      failures++;
      $display("FAIL midrst_gnt got=%b want=1", bus.o_ls_gnt);
    end
    next_cycle();
    rst = 1'b1;
    drive(1'b1, 10'h080, 1'b0, 1'b1, 1'b0, 10'h010, '0);
    @(negedge clk);
    checks++;
    if (all_out() !== '0) begin
      failures++;
      $display("FAIL midrst_outputs got=%h want=0", all_out());
    end
    next_cycle();
    rst = 1'b0;
    idle();
    @(negedge clk);
    checks++;
    if ({bus.o_if_vld, bus.o_ls_vld, bus.o_mem_en} !== 3'b000) begin
      failures++;
      $display("FAIL midrst_release got ifvld=%b lsvld=%b en=%b want 0 0 0",
               bus.o_if_vld, bus.o_ls_vld, bus.o_mem_en);
    end
    next_cycle();
  endtask

  // Model: fetch waits behind load/store until it has been refused MAX_WAIT times in a row.
  task automatic test_random();
    logic          ifr = 1'b0, lr = 1'b0, lwe = 1'b0, fl, fw, lw;
    logic [AW-1:0] ia = '0, la = '0;
    logic [DW-1:0] lwd = '0, prev_data = '0;
    int            streak = 0;
    int            prev = 0;  // 0 none, 1 fetch, 2 load, 3 store
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    for (int n = 0; n < 400; n++) begin
      if (!ifr) begin
        ifr = ($urandom_range(0, 1) == 1);
        ia  = 10'($urandom_range(0, 15));
      end
      if (!lr) begin
        lr  = ($urandom_range(0, 2) != 0);
        lwe = ($urandom_range(0, 1) == 1);
        la  = 10'($urandom_range(0, 15));
        lwd = $urandom;
      end
      fl = ($urandom_range(0, 7) == 0);
      drive(ifr, ia, fl, lr, lwe, la, lwd);
      fw      = ifr && !fl && (!lr || streak >= MAXW);
      lw      = lr && !fw;
      e_addr  = fw ? ia : (lw ? la : '0);
      e_wdata = lw ? lwd : '0;
      @(negedge clk);
      checks++;
      if ({bus.o_if_gnt, bus.o_ls_gnt, bus.o_mem_en, bus.o_mem_we, bus.o_mem_addr,
           bus.o_mem_wdata} !== {fw, lw, fw | lw, lw & lwe, e_addr, e_wdata}) begin
        failures++;
        $display("FAIL rand_cmd n=%0d got if=%b ls=%b en=%b we=%b a=%h d=%h want %b %b %b %b %h %h",
                 n, bus.o_if_gnt, bus.o_ls_gnt, bus.o_mem_en, bus.o_mem_we, bus.o_mem_addr,
                 bus.o_mem_wdata, fw, lw, fw | lw, lw & lwe, e_addr, e_wdata);
      end
      checks++;
      if ({bus.o_if_vld, bus.o_if_rdata, bus.o_ls_vld, bus.o_ls_rdata} !==
          {(prev == 1 && !fl), (prev == 1 && !fl) ? prev_data : 32'h0,
           (prev >= 2), (prev == 2) ? prev_data : 32'h0}) begin
        failures++;
        $display("FAIL rand_resp n=%0d got ifv=%b ifd=%h lsv=%b lsd=%h prev=%0d fl=%b data=%h",
                 n, bus.o_if_vld, bus.o_if_rdata, bus.o_ls_vld, bus.o_ls_rdata, prev, fl,
                 prev_data);
      end
      streak = (fw || !ifr || fl) ? 0 : ((streak < 15) ? streak + 1 : 15);
      if (fw) begin
        prev      = 1;
        prev_data = ref_mem[ia];
        ifr       = 1'b0;
      end else if (lw) begin
        prev = lwe ? 3 : 2;
        if (lwe) ref_mem[la] = lwd;
        else     prev_data   = ref_mem[la];
        lr = 1'b0;
      end else begin
        prev = 0;
      end
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'hA000_0000 | i;
      ref_mem[i] = 32'hA000_0000 | i;
    end
    mem[10'h080]     = 32'hDEAD_BEEF;
    ref_mem[10'h080] = 32'hDEAD_BEEF;
    ref_mem[10'h3FF] = 32'h1234_5678;
    test_reset();
    test_lone_fetch();
    test_conflict();
    test_starvation();
    test_store();
    test_flush();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arb.md
# mem_port_arb

Single-cycle arbiter that shares the processor's one single-port memory between the instruction-fetch requester and the load/store requester. It sits between the datapath's fetch and memory-access logic and the memory array. Load/store normally wins; a starvation counter guarantees fetch progress. A flush input discards an in-flight fetch on redirect.

## Interface
- DATA_WIDTH, 32, memory word width
- MEM_DEPTH, 1024, memory words; ADDR_W = $clog2(MEM_DEPTH) is a derived localparam
- MAX_WAIT, 4, consecutive denied fetch cycles before fetch takes priority (1..15)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_if_req  in  1  fetch request, held until granted
- i_if_addr  in  ADDR_W  fetch word address
- i_if_flush  in  1  discard in-flight fetch, block fetch grant this cycle
- o_if_gnt  out  1  fetch accepted this cycle
- o_if_vld  out  1  fetch read data valid
- o_if_rdata  out  DATA_WIDTH  fetch read data
- i_ls_req  in  1  load/store request, held until granted
- i_ls_we  in  1  1 = store, 0 = load
- i_ls_addr  in  ADDR_W  data word address
- i_ls_wdata  in  DATA_WIDTH  store data
- o_ls_gnt  out  1  load/store accepted this cycle
- o_ls_vld  out  1  load data valid / store acknowledge
- o_ls_rdata  out  DATA_WIDTH  load read data
- o_mem_en  out  1  memory access strobe
- o_mem_we  out  1  memory write enable
- o_mem_addr  out  ADDR_W  memory address
- o_mem_wdata  out  DATA_WIDTH  memory write data
- i_mem_rdata  in  DATA_WIDTH  memory read data, valid one cycle after a read strobe

## Operation
- State: owner_q in {NONE, IF, LS_RD, LS_WR} = owner of last cycle's access; wait_q = 4-bit saturating fetch wait counter.
- Eligibility: if_ok = i_if_req & ~i_if_flush; ls_ok = i_ls_req.
- Priority: fetch wins if if_ok & (~ls_ok | wait_q >= MAX_WAIT); otherwise LS wins if ls_ok.
- At most one grant per cycle. o_if_gnt and o_ls_gnt are never both 1.
- On grant, the memory command is driven combinationally in the same cycle: o_mem_en=1, address/we/wdata muxed from the winner; o_mem_we=0 for fetch.
- With no grant: o_mem_en=0, o_mem_we=0; address and wdata are don't-care and are driven 0.
- wait_q:
  - increments (saturating at 15) when if_ok & ~o_if_gnt;
  - clears when o_if_gnt, or when i_if_req=0, or when i_if_flush=1.
- owner_q <= winner each cycle (NONE if no grant).
- Responses:
  - o_if_vld = (owner_q==IF) & ~i_if_flush;
  - o_ls_vld = (owner_q==LS_RD | owner_q==LS_WR);
  - o_if_rdata and o_ls_rdata = i_mem_rdata when their vld is 1, otherwise 0;
  - o_ls_rdata = 0 on a store acknowledge.
- Flush: kills the response of the fetch granted in the previous cycle and denies any fetch grant in the flush cycle. A load/store may still be granted in a flush cycle.

## Timing
- Grant and memory command: combinational, same cycle as request (zero cycles).
- Response: exactly 1 cycle after grant. Back-to-back grants every cycle give full throughput.
- Worst-case fetch latency under continuous LS traffic: MAX_WAIT denied cycles, then granted on cycle MAX_WAIT+1.
- Reset (rst=1, asynchronous):
  - owner_q=NONE, wait_q=0;
  - all grants, o_mem_en, o_mem_we, vld and rdata outputs are 0 while rst is high, with grants gated by rst;
  - reset mid-operation drops any in-flight response, and no vld fires after release.
- First grant is possible in the first cycle with rst low.
- Simultaneous cases:
  - flush in the same cycle as a fetch response: response suppressed;
  - flush and LS request together: LS granted.
- Requesters must hold req, addr and data stable until gnt. The arbiter does not latch requests.

## Test plan
- Lone fetch: i_if_req=1, addr=0x080 for one cycle, i_mem_rdata=0xDEADBEEF next cycle -> o_if_gnt=1, o_mem_en=1, o_mem_addr=0x080, o_mem_we=0; next cycle o_if_vld=1, o_if_rdata=0xDEADBEEF.
- Conflict: if_req and ls_req (load, addr 0x010) both 1 with wait_q=0 -> o_ls_gnt=1, o_if_gnt=0; next cycle o_ls_vld=1, o_if_vld=0, wait_q=1.
- Starvation (MAX_WAIT=4):
  - stimulus: continuous ls_req and if_req for 6 cycles;
  - LS granted in cycles 0-3, fetch granted in cycle 4, LS in cycle 5;
  - wait_q reaches 4, then 0.
- Store: ls_req=1, we=1, addr=0x3FF, wdata=0x12345678 -> o_mem_we=1, o_mem_wdata=0x12345678 same cycle; next cycle o_ls_vld=1, o_ls_rdata=0.
- Flush: fetch granted in cycle N, i_if_flush=1 in cycle N+1 with if_req=1 -> o_if_vld=0 and o_if_gnt=0 in N+1; fetch granted in N+2.
- Reset mid-op: load granted, rst pulsed high on the next edge -> o_ls_vld=0 and all outputs 0 during reset; no stray vld after rst falls.
